// File: rtl/cpu_pkg.sv
// Shared CPU constants and types.
//   DATA_WIDTH / ADDR_WIDTH : register data and index widths
//   NUM_REGS                : architectural registers tracked by scoreboards
//   ZERO_REG                : XZR index; never written, never busy
//   pri_state_t             : writeback arbiter priority state
package cpu_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 32;
  localparam int ZERO_REG   = 31;

  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_MEM = 1'b1
  } pri_state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
//   clock, reset             : rising-edge clock, async active-high reset
//   set_valid / set_addr     : a producer was issued for set_addr
//   clear_valid / clear_addr : the write for clear_addr is leaving for the regfile
//   check_addr1/2, busy1/2   : combinational read ports (no same-cycle bypass)
module regfile_scoreboard
  import cpu_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  set_valid,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic                  clear_valid,
  input  logic [ADDR_WIDTH-1:0] clear_addr,
  input  logic [ADDR_WIDTH-1:0] check_addr1,
  input  logic [ADDR_WIDTH-1:0] check_addr2,
  output logic                  busy1,
  output logic                  busy2
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clear_mask;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    set_mask   = '0;
    clear_mask = '0;
    if (set_valid && (set_addr != ADDR_WIDTH'(ZERO_REG)))
      set_mask[set_addr] = 1'b1;
    if (clear_valid)
      clear_mask[clear_addr] = 1'b1;
  end

  // Clear first, then set: a new producer issued on the same edge as the old
  // producer's writeback keeps the register busy.
  // NOTE: the busy vector is a bank of flops, not a RAM, so it is reset
  // directly; a RAM-style array would need an explicit clear sequence.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      // NOTE: non-blocking assignment for all sequential state so every flop
      // samples pre-edge values regardless of statement order.
      busy_q <= (busy_q & ~clear_mask) | set_mask;
    end
  end

  // XZR can never be set, but the read is masked too so the port contract
  // holds independently of the set path.
  assign busy1 = (check_addr1 != ADDR_WIDTH'(ZERO_REG)) && busy_q[check_addr1];
  assign busy2 = (check_addr2 != ADDR_WIDTH'(ZERO_REG)) && busy_q[check_addr2];

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU
// and memory-load writeback sources, plus the pending-write scoreboard.
//   clock, reset                     : rising-edge clock, async active-high reset
//   alu_valid/ready/addr/data        : ALU writeback handshake
//   mem_valid/ready/addr/data        : load writeback handshake
//   issue_valid, issue_addr          : decode marks a destination as pending
//   check_addr1/2, busy1/2           : decode source-operand hazard queries
//   reg_write, write_register, write_data : registered regfile write port
module regfile_write_arbiter
  import cpu_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_addr,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  input  logic [ADDR_WIDTH-1:0] check_addr1,
  input  logic [ADDR_WIDTH-1:0] check_addr2,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  reg_write,
  output logic [ADDR_WIDTH-1:0] write_register,
  output logic [DATA_WIDTH-1:0] write_data
);

  pri_state_t            state_q, state_d;
  logic                  grant_alu, grant_mem;
  logic                  xfer_valid;
  logic [ADDR_WIDTH-1:0] xfer_addr;
  logic [DATA_WIDTH-1:0] xfer_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= PRI_MEM;
    else       state_q <= state_d;
  end

  // Grants are suppressed while reset is high so no handshake can complete
  // into flops that are being held clear.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    state_d   = state_q;
    if (!reset) begin
      if (alu_valid && mem_valid) begin
        if (state_q == PRI_ALU) grant_alu = 1'b1;
        else                    grant_mem = 1'b1;
      end else if (alu_valid) begin
        grant_alu = 1'b1;
      end else if (mem_valid) begin
        grant_mem = 1'b1;
      end
    end
    // Whoever won hands priority to the other source; idle cycles keep it.
    if (grant_alu)      state_d = PRI_MEM;
    else if (grant_mem) state_d = PRI_ALU;
  end

  assign alu_ready  = grant_alu;
  assign mem_ready  = grant_mem;
  assign xfer_valid = grant_alu | grant_mem;
  assign xfer_addr  = grant_alu ? alu_addr : mem_addr;
  assign xfer_data  = grant_alu ? alu_data : mem_data;

  // A transfer to XZR is accepted and loads the index/data registers, but the
  // write enable stays low so the regfile never sees it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_write      <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
    end else begin
      reg_write <= xfer_valid && (xfer_addr != ADDR_WIDTH'(ZERO_REG));
      if (xfer_valid) begin
        write_register <= xfer_addr;
        write_data     <= xfer_data;
      end
    end
  end

  regfile_scoreboard u_scoreboard (
    .clock       (clock),
    .reset       (reset),
    .set_valid   (issue_valid),
    .set_addr    (issue_addr),
    .clear_valid (xfer_valid),
    .clear_addr  (xfer_addr),
    .check_addr1 (check_addr1),
    .check_addr2 (check_addr2),
    .busy1       (busy1),
    .busy2       (busy2)
  );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios followed
// by randomized traffic, all compared against a behavioural model.
module tb_regfile_write_arbiter;
  import cpu_pkg::*;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  alu_valid, alu_ready;
  logic [ADDR_WIDTH-1:0] alu_addr;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  mem_valid, mem_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  issue_valid;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [ADDR_WIDTH-1:0] check_addr1, check_addr2;
  logic                  busy1, busy2;
  logic                  reg_write;
  logic [ADDR_WIDTH-1:0] write_register;
  logic [DATA_WIDTH-1:0] write_data;

  always #5 clock = ~clock;

  regfile_write_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_addr       (alu_addr),
    .alu_data       (alu_data),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .issue_valid    (issue_valid),
    .issue_addr     (issue_addr),
    .check_addr1    (check_addr1),
    .check_addr2    (check_addr2),
    .busy1          (busy1),
    .busy2          (busy2),
    .reg_write      (reg_write),
    .write_register (write_register),
    .write_data     (write_data)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Priority: name of the source that wins a tie ("alu" or "mem").
  string         m_tie_winner;
  bit            m_busy[NUM_REGS];
  logic          m_we;
  logic [4:0]    m_wr;
  logic [63:0]   m_wd;
  bit            m_wport_known;   // index/data after an XZR transfer are not checked
  bit            last_ga, last_gm;
  int            last_wr_log[$];

  task automatic model_reset();
    m_tie_winner  = "mem";
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_we          = 1'b0;
    m_wr          = '0;
    m_wd          = '0;
    m_wport_known = 1'b1;
  endtask

  function automatic bit m_busy_of(input int a);
    return (a == ZERO_REG) ? 1'b0 : m_busy[a];
  endfunction

  // One clock cycle: inputs were driven at the preceding falling edge.
  task automatic cycle();
    bit ga, gm;
    int xa;
    logic [63:0] xd;
    #1;
    ga = 0; gm = 0;
    if (alu_valid && mem_valid) begin
      if (m_tie_winner == "alu") ga = 1; else gm = 1;
    end else begin
      ga = alu_valid;
      gm = mem_valid;
    end
    check("alu_ready", alu_ready, ga);
    check("mem_ready", mem_ready, gm);
    check("busy1", busy1, m_busy_of(check_addr1));
    check("busy2", busy2, m_busy_of(check_addr2));
    @(posedge clock);
    last_ga = ga; last_gm = gm;
    m_we = 1'b0;
    if (ga || gm) begin
      xa = ga ? int'(alu_addr) : int'(mem_addr);
      xd = ga ? alu_data : mem_data;
      m_tie_winner = ga ? "mem" : "alu";
      m_busy[xa] = 1'b0;
      if (xa != ZERO_REG) begin
        m_we = 1'b1; m_wr = 5'(xa); m_wd = xd; m_wport_known = 1'b1;
      end else begin
        m_wport_known = 1'b0;
      end
    end
    if (issue_valid && issue_addr != 5'(ZERO_REG)) m_busy[issue_addr] = 1'b1;
    @(negedge clock);
    check("reg_write", reg_write, m_we);
    if (m_wport_known) begin
      check("write_register", write_register, m_wr);
      check("write_data", write_data, m_wd);
    end
    if (reg_write) last_wr_log.push_back(int'(write_register));
  endtask

  task automatic idle();
    alu_valid = 0; mem_valid = 0; issue_valid = 0;
    alu_addr = '0; mem_addr = '0; alu_data = '0; mem_data = '0; issue_addr = '0;
  endtask

  initial begin
    int exp_seq[4];
    exp_seq[0] = 5; exp_seq[1] = 4; exp_seq[2] = 5; exp_seq[3] = 4;
    idle();
    check_addr1 = 0; check_addr2 = 0;
    reset = 1'b1;
    model_reset();
    // Requests during reset must not be granted.
    alu_valid = 1; mem_valid = 1; alu_addr = 1; mem_addr = 2;
    #2;
    check("rst_alu_ready", alu_ready, 0);
    check("rst_mem_ready", mem_ready, 0);
    check("rst_reg_write", reg_write, 0);
    check("rst_write_register", write_register, 0);
    check("rst_write_data", write_data, 0);
    check("rst_busy1", busy1, 0);
    repeat (2) @(negedge clock);
    idle();
    reset = 1'b0;

    // Single ALU write.
    alu_valid = 1; alu_addr = 3; alu_data = 64'hAA;
    cycle();
    check("t1_grant", last_ga, 1);
    check("t1_we", reg_write, 1);
    check("t1_reg", write_register, 3);
    check("t1_data", write_data, 64'hAA);
    idle();

    // Both sources held valid: round robin starting from MEM.
    last_wr_log.delete();
    alu_valid = 1; alu_addr = 4; alu_data = 64'h44;
    mem_valid = 1; mem_addr = 5; mem_data = 64'h55;
    repeat (4) cycle();
    idle();
    check("rr_len", last_wr_log.size(), 4);
    for (int i = 0; i < 4 && i < last_wr_log.size(); i++)
      check("rr_seq", last_wr_log[i], exp_seq[i]);

    // Load to XZR: accepted, no write; priority rotates to ALU.
    mem_valid = 1; mem_addr = 31; mem_data = 64'h55;
    cycle();
    check("xzr_grant", last_gm, 1);
    check("xzr_we", reg_write, 0);
    alu_valid = 1; alu_addr = 6; alu_data = 64'h66;
    mem_valid = 1; mem_addr = 8; mem_data = 64'h88;
    cycle();
    check("xzr_next_alu", last_ga, 1);
    mem_valid = 0; alu_valid = 0;
    idle();

    // Scoreboard set then clear.
    check_addr1 = 7;
    issue_valid = 1; issue_addr = 7;
    cycle();
    idle();
    #1 check("sb_set", busy1, 1);
    alu_valid = 1; alu_addr = 7; alu_data = 64'h77;
    cycle();
    idle();
    #1 check("sb_clear", busy1, 0);

    // Set and clear same index: set wins. XZR never busy.
    check_addr1 = 9; check_addr2 = 31;
    issue_valid = 1; issue_addr = 9;
    mem_valid = 1; mem_addr = 9; mem_data = 64'h99;
    cycle();
    idle();
    issue_valid = 1; issue_addr = 31;
    cycle();
    idle();
    #1;
    check("sb_set_wins", busy1, 1);
    check("sb_xzr", busy2, 0);

    // Asynchronous reset while a write is on the port.
    check_addr1 = 20; check_addr2 = 9;
    issue_valid = 1; issue_addr = 20;
    alu_valid = 1; alu_addr = 12; alu_data = 64'hC0FFEE;
    cycle();
    idle();
    #2;
    check("pre_rst_we", reg_write, 1);
    check("pre_rst_busy1", busy1, 1);
    alu_valid = 1; alu_addr = 13;
    reset = 1'b1;
    #1;
    check("arst_we", reg_write, 0);
    check("arst_reg", write_register, 0);
    check("arst_busy1", busy1, 0);
    check("arst_busy2", busy2, 0);
    check("arst_ready", alu_ready, 0);
    @(negedge clock);
    idle();
    reset = 1'b0;
    model_reset();
    alu_valid = 1; alu_addr = 1; alu_data = 64'h1;
    mem_valid = 1; mem_addr = 2; mem_data = 64'h2;
    cycle();
    check("arst_pri_mem", last_gm, 1);
    idle();

    // Randomized traffic; sources hold requests until granted.
    for (int n = 0; n < 3000; n++) begin
      if (!alu_valid || last_ga) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_addr  = 5'($urandom_range(0, 31));
        alu_data  = {$urandom, $urandom};
      end
      if (!mem_valid || last_gm) begin
        mem_valid = ($urandom_range(0, 2) != 0);
        mem_addr  = 5'($urandom_range(0, 31));
        mem_data  = {$urandom, $urandom};
      end
      issue_valid = $urandom_range(0, 1);
      issue_addr  = 5'($urandom_range(0, 31));
      check_addr1 = 5'($urandom_range(0, 31));
      check_addr2 = 5'($urandom_range(0, 31));
      last_ga = 0; last_gm = 0;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
